// File: rtl/isa_bus_cycle_engine_if.sv
// isa_bus_cycle_engine_if: command/response handshake plus ISA pin bundle for the bus cycle engine
interface isa_bus_cycle_engine_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_timeout;
    logic [ADDR_WIDTH-1:0] isa_addr;
    logic [DATA_WIDTH-1:0] isa_data_out;
    logic                  isa_data_oe;
    logic [DATA_WIDTH-1:0] isa_data_in;
    logic                  isa_ale;
    logic                  isa_aen;
    logic                  isa_ior;
    logic                  isa_iow;
    logic                  isa_chrdy;
    logic                  busy;
    logic [LW-1:0]         fifo_level;
    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, isa_data_in, isa_chrdy,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, isa_addr, isa_data_out, isa_data_oe,
               isa_ale, isa_aen, isa_ior, isa_iow, busy, fifo_level
    );
    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, isa_data_in, isa_chrdy,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, isa_addr, isa_data_out, isa_data_oe,
               isa_ale, isa_aen, isa_ior, isa_iow, busy, fifo_level
    );
endinterface

// File: rtl/isa_bus_cycle_engine.sv
// isa_bus_cycle_engine: FIFO-fed ISA I/O cycle generator with programmable ALE/strobe timing,
// isa_chrdy wait states with timeout, and a response handshake.
module isa_bus_cycle_engine #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int ALE_CYCLES     = 2,
    parameter int STROBE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic                   isa_clk,
    input logic                   isa_reset,
    isa_bus_cycle_engine_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int M1 = ALE_CYCLES > STROBE_CYCLES ? ALE_CYCLES : STROBE_CYCLES;
    localparam int MC = M1 > TIMEOUT_CYCLES ? M1 : TIMEOUT_CYCLES;
    localparam int CW = $clog2(MC + 1);
    localparam logic [CW-1:0] ALE_LAST = CW'(ALE_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, ADDR, SETUP, STROBE, WAIT, HOLD, RESP} state_t;

    state_t                state, state_d;
    logic [CW-1:0]         cnt, cnt_d;
    logic [EW-1:0]         mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [LW-1:0]         level;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic                  timeout_q;
    logic                  push, pop, leave, expire, strobe;

    // cmd_ready depends on level only, so a full FIFO never accepts even while popping
    assign bus.cmd_ready    = level < LW'(FIFO_DEPTH);
    assign push             = bus.cmd_valid && bus.cmd_ready;
    assign strobe           = state == STROBE || state == WAIT;
    assign bus.isa_ale      = state == ADDR;
    assign bus.isa_aen      = state == ADDR;
    assign bus.isa_ior      = !(strobe && !write_q);
    assign bus.isa_iow      = !(strobe && write_q);
    assign bus.isa_data_oe  = write_q && (state inside {SETUP, STROBE, WAIT, HOLD});
    assign bus.isa_addr     = addr_q;
    assign bus.isa_data_out = wdata_q;
    assign bus.rsp_valid    = state == RESP;
    assign bus.rsp_rdata    = rdata_q;
    assign bus.rsp_timeout  = timeout_q;
    assign bus.busy         = state != IDLE || level != '0;
    assign bus.fifo_level   = level;

    always_comb begin
        state_d = state;
        cnt_d   = '0;
        pop     = 1'b0;
        leave   = 1'b0;
        expire  = 1'b0;
        case (state)
            IDLE: if (level != '0) begin
                pop     = 1'b1;
                state_d = ADDR;
            end
            ADDR: if (cnt == ALE_LAST) state_d = SETUP; else cnt_d = cnt + 1'b1;
            SETUP: state_d = STROBE;
            STROBE: if (cnt == STB_LAST) begin
                leave   = bus.isa_chrdy;
                state_d = bus.isa_chrdy ? HOLD : WAIT;
            end else cnt_d = cnt + 1'b1;
            WAIT: begin
                expire  = !bus.isa_chrdy && cnt == TO_LAST;
                leave   = bus.isa_chrdy || expire;
                state_d = leave ? HOLD : WAIT;
                cnt_d   = cnt + 1'b1;
            end
            HOLD: state_d = RESP;
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge isa_clk)
        if (push) mem[wr_ptr] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};

    always_ff @(posedge isa_clk or negedge isa_reset) begin
        if (!isa_reset) begin
            state     <= IDLE;
            cnt       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            level <= level + LW'(push) - LW'(pop);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr                      <= rd_ptr + 1'b1;
                {write_q, addr_q, wdata_q} <= mem[rd_ptr];
                rdata_q                     <= '0;
                timeout_q                   <= 1'b0;
            end
            if (leave && !write_q) rdata_q <= expire ? '1 : bus.isa_data_in;
            if (expire) timeout_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_isa_bus_cycle_engine.sv
// tb_isa_bus_cycle_engine: randomized bench; a cycle-timeline model predicts every output
// from each command's pop time and its planned isa_chrdy wait length.
module tb_isa_bus_cycle_engine;
    localparam int AW = 10, DW = 8, DEPTH = 4, ALE = 2, STB = 4, TO = 64;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rd;
        int            nw;
    } cmd_t;

    logic isa_clk = 1'b0;
    logic isa_reset = 1'b0;
    always #5 isa_clk = ~isa_clk;

    isa_bus_cycle_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

    isa_bus_cycle_engine #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
        .ALE_CYCLES(ALE), .STROBE_CYCLES(STB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .isa_clk(isa_clk),
        .isa_reset(isa_reset),
        .bus(bus)
    );

    cmd_t push_q[$], fifo_q[$], cur;
    int   n_checks = 0, n_fail = 0, cyc = 0, pop_cyc = 0, slen = 0;
    int   valid_pct = 100, ready_pct = 100;
    bit   eng = 1'b0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic cmd_t mk(logic w, logic [AW-1:0] a, logic [DW-1:0] wd, logic [DW-1:0] rd, int nw);
        cmd_t c;
        c.write = w;
        c.addr  = a;
        c.wdata = wd;
        c.rd    = rd;
        c.nw    = nw;
        return c;
    endfunction

    // One clock: compare at the negedge, drive inputs for this cycle, advance the model.
    task automatic tick();
        int rel, k, lvl;
        bit a_ale, a_stb, a_oe, a_rv, a_push, a_pop, a_hs;
        @(negedge isa_clk);
        lvl   = fifo_q.size();
        rel   = cyc - pop_cyc;
        a_ale = eng && rel >= 1 && rel <= ALE;
        a_stb = eng && rel >= ALE + 2 && rel <= ALE + 1 + slen;
        a_oe  = eng && cur.write && rel >= ALE + 1 && rel <= ALE + 2 + slen;
        a_rv  = eng && rel >= ALE + 3 + slen;
        check("ctl", {bus.isa_ale, bus.isa_aen, bus.isa_ior, bus.isa_iow, bus.isa_data_oe,
                      bus.rsp_valid, bus.cmd_ready, bus.busy},
                     {a_ale, a_ale, !(a_stb && !cur.write), !(a_stb && cur.write), a_oe,
                      a_rv, lvl < DEPTH, eng || lvl > 0});
        check("level", 32'(bus.fifo_level), lvl);
        if (eng) check("addr", 32'(bus.isa_addr), 32'(cur.addr));
        if (eng && cur.write) check("dout", 32'(bus.isa_data_out), 32'(cur.wdata));
        if (a_rv) begin
            check("rdata", 32'(bus.rsp_rdata), cur.write ? 32'h0 : cur.nw > TO ? 32'hFF : 32'(cur.rd));
            check("timeout", 32'(bus.rsp_timeout), 32'(cur.nw > TO));
        end
        bus.cmd_valid = push_q.size() > 0 && $urandom_range(99) < valid_pct;
        bus.cmd_write = push_q.size() > 0 ? push_q[0].write : 1'($urandom_range(1));
        bus.cmd_addr  = push_q.size() > 0 ? push_q[0].addr : AW'($urandom);
        bus.cmd_wdata = push_q.size() > 0 ? push_q[0].wdata : DW'($urandom);
        bus.rsp_ready = $urandom_range(99) < ready_pct;
        bus.isa_chrdy   = 1'($urandom_range(1));
        bus.isa_data_in = DW'($urandom);
        k = rel - (ALE + 1);
        if (eng && k >= STB && k <= slen) bus.isa_chrdy = k >= STB + cur.nw;
        if (eng && k == slen) bus.isa_data_in = cur.rd;
        a_push = bus.cmd_valid && lvl < DEPTH;
        a_pop  = !eng && lvl > 0;
        a_hs   = a_rv && bus.rsp_ready;
        if (a_hs) eng = 1'b0;
        if (a_pop) begin
            cur     = fifo_q.pop_front();
            eng     = 1'b1;
            pop_cyc = cyc;
            slen    = STB + (cur.nw > TO ? TO : cur.nw);
        end
        if (a_push) fifo_q.push_back(push_q.pop_front());
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 4000 && (push_q.size() > 0 || fifo_q.size() > 0 || eng); i++) tick();
        repeat (2) tick();
    endtask

    initial begin
        int r, nw;
        bit w;
        cur = mk(1'b0, '0, '0, '0, 0);
        bus.cmd_valid   = 1'b0;
        bus.cmd_write   = 1'b0;
        bus.cmd_addr    = '0;
        bus.cmd_wdata   = '0;
        bus.rsp_ready   = 1'b1;
        bus.isa_chrdy   = 1'b1;
        bus.isa_data_in = '0;
        repeat (3) tick();
        check("rst_addr", 32'(bus.isa_addr), 0);
        check("rst_dout", 32'(bus.isa_data_out), 0);
        check("rst_rdata", 32'(bus.rsp_rdata), 0);
        check("rst_timeout", 32'(bus.rsp_timeout), 0);
        #2 isa_reset = 1'b1;

        push_q.push_back(mk(1'b1, 10'h106, 8'hA6, 8'h00, 0));
        drain();
        push_q.push_back(mk(1'b0, 10'h100, 8'h00, 8'h5A, 0));
        drain();
        push_q.push_back(mk(1'b0, 10'h102, 8'h00, 8'h3C, 3));
        drain();
        push_q.push_back(mk(1'b0, 10'h104, 8'h00, 8'h77, 200));
        push_q.push_back(mk(1'b0, 10'h105, 8'h00, 8'h11, 0));
        drain();
        push_q.push_back(mk(1'b0, 10'h108, 8'h00, 8'hC3, TO));
        push_q.push_back(mk(1'b0, 10'h109, 8'h00, 8'h96, TO + 1));
        drain();

        ready_pct = 0;
        for (int i = 0; i < 5; i++) push_q.push_back(mk(i[0], AW'(10'h110 + i), DW'(8'h20 + i), DW'(8'h40 + i), 0));
        repeat (40) tick();
        ready_pct = 100;
        drain();

        valid_pct = 60;
        ready_pct = 70;
        for (int i = 0; i < 40; i++) begin
            w  = 1'($urandom_range(1));
            r  = int'($urandom_range(9));
            nw = r < 5 ? 0 : r < 8 ? int'($urandom_range(6, 1)) : int'($urandom_range(TO + 8, TO - 2));
            if (w && nw > TO) nw = TO;
            push_q.push_back(mk(w, AW'($urandom), DW'($urandom), DW'($urandom), nw));
        end
        drain();

        valid_pct = 100;
        ready_pct = 100;
        push_q.push_back(mk(1'b1, 10'h1A0, 8'h55, 8'h00, 10));
        push_q.push_back(mk(1'b0, 10'h1A1, 8'h00, 8'h12, 0));
        push_q.push_back(mk(1'b0, 10'h1A2, 8'h00, 8'h34, 0));
        for (int i = 0; i < 200 && !(eng && cur.write && cyc - 1 - pop_cyc == ALE + 3); i++) tick();
        check("pre_rst_iow", 32'(bus.isa_iow), 0);
        #2 isa_reset = 1'b0;
        #1;
        check("rst_iow", 32'(bus.isa_iow), 1);
        check("rst_ior", 32'(bus.isa_ior), 1);
        check("rst_oe", 32'(bus.isa_data_oe), 0);
        check("rst_level", 32'(bus.fifo_level), 0);
        check("rst_rv", 32'(bus.rsp_valid), 0);
        check("rst_busy", 32'(bus.busy), 0);
        push_q.delete();
        fifo_q.delete();
        eng = 1'b0;
        repeat (3) tick();
        #2 isa_reset = 1'b1;
        push_q.push_back(mk(1'b0, 10'h1B0, 8'h00, 8'hE7, 2));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/isa_bus_cycle_engine.md
Name: isa_bus_cycle_engine

Overview:
Synthesizable, parametrised ISA I/O cycle generator for board self-test and bring-up of the ISA-CAMAC interface. It replaces hand-timed stimulus with a command FIFO. It issues ALE/IOR/IOW cycles at programmable timing, honours isa_chrdy wait states with a timeout, and returns read data through a response handshake. It sits between an internal command source (test sequencer or debug port) and the ISA-side pins of sm2201_interface_board.

Parameters:
ADDR_WIDTH, 10, ISA I/O address width
DATA_WIDTH, 8, data width (8 or 16)
FIFO_DEPTH, 4, command FIFO entries (power of two, >=2)
ALE_CYCLES, 2, clocks ALE/AEN held high per cycle (>=1)
STROBE_CYCLES, 4, minimum clocks IOR/IOW held low (>=1)
TIMEOUT_CYCLES, 64, max extra wait clocks while isa_chrdy low

Ports:
isa_clk  in  1  sole clock, all logic rising-edge
isa_reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept
cmd_write  in  1  1 = IOW cycle, 0 = IOR cycle
cmd_addr  in  ADDR_WIDTH  target I/O address
cmd_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
rsp_timeout  out  1  cycle terminated by timeout
isa_addr  out  ADDR_WIDTH  bus address
isa_data_out  out  DATA_WIDTH  bus write data
isa_data_oe  out  1  drive isa_data_out onto bus
isa_data_in  in  DATA_WIDTH  bus read data
isa_ale  out  1  address latch enable
isa_aen  out  1  mirrors isa_ale
isa_ior  out  1  read strobe, active-low
isa_iow  out  1  write strobe, active-low
isa_chrdy  in  1  channel ready, low = wait
busy  out  1  FSM not IDLE or FIFO non-empty
fifo_level  out  $clog2(FIFO_DEPTH)+1  entries queued

Behaviour:
- Reset (isa_reset=0, async): FSM=IDLE, FIFO flushed, fifo_level=0, cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_timeout=0, isa_addr=0, isa_data_out=0, isa_data_oe=0, isa_ale=0, isa_aen=0, isa_ior=1, isa_iow=1, busy=0. Asserting reset mid-cycle releases strobes immediately. The aborted command produces no response.
- FIFO: push on cmd_valid&&cmd_ready. cmd_ready=(level<FIFO_DEPTH). There is no bypass when full, even if a pop occurs in the same clock. Push and pop in the same clock leave the level unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, ADDR, SETUP, STROBE, WAIT, HOLD, RESP.
- IDLE: pop the FIFO head if non-empty and rsp_valid=0, then go to ADDR. Latch addr, write, wdata. Drive isa_addr.
- ADDR: isa_ale=isa_aen=1 for ALE_CYCLES clocks. Go to SETUP.
- SETUP: 1 clock with ALE=0 and address stable. For writes, isa_data_oe=1 from here until HOLD ends. Go to STROBE.
- STROBE: isa_iow (write) or isa_ior (read) low for exactly STROBE_CYCLES clocks. On the last clock, if isa_chrdy=1 go to HOLD, else go to WAIT.
- WAIT: the strobe stays low. Count clocks while isa_chrdy=0. When isa_chrdy=1, go to HOLD. If the count reaches TIMEOUT_CYCLES, set the timeout flag and go to HOLD.
- Read data: isa_data_in is registered on the clock that leaves STROBE/WAIT. On timeout, rdata = all ones.
- HOLD: strobe high for 1 clock, address and write data held. Then isa_data_oe=0 and go to RESP.
- RESP: rsp_valid=1 with rdata/timeout. Hold until rsp_ready=1, then clear rsp_valid and go to IDLE.
- Zero-wait latency from pop to rsp_valid: ALE_CYCLES+STROBE_CYCLES+3 clocks (defaults: 9).
- isa_chrdy is sampled only in the last STROBE clock and in WAIT.
- isa_ior and isa_iow are never low simultaneously.

Test Plan:
- Write: cmd {write=1, addr=106h, wdata=A6h}, chrdy=1 -> ALE high 2 clocks, iow low exactly 4 clocks, isa_addr=106h and isa_data_out=A6h with oe=1 throughout, rsp_valid 9 clocks after pop, rdata=00h, timeout=0.
- Read: cmd {write=0, addr=100h}, bus drives 5Ah, chrdy=1 -> ior low 4 clocks, oe=0, rsp_rdata=5Ah.
- Wait states: read 102h, chrdy low for 3 clocks after the 4th strobe clock -> ior low 7 clocks total, rdata captured after chrdy rises, timeout=0.
- Timeout: chrdy held low -> strobe low 4+64 clocks, rsp_timeout=1, rsp_rdata=FFh, next command proceeds normally.
- FIFO/backpressure: push 5 commands back-to-back with rsp_ready=0 -> first popped, 4 queued, cmd_ready=0 at level 4, no second bus cycle until rsp_ready pulses. Commands complete in push order.
- Reset mid-cycle: assert isa_reset during STROBE of a write -> iow=1 and oe=0 asynchronously, FIFO empty, no rsp_valid. Normal operation resumes after release.
